// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: keeps the grant through fixed-length bursts and locked
// sequences, and masks SPLIT masters until their slave releases them.
module ahb_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int MW = $clog2(NO_OF_MASTERS)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [NO_OF_MASTERS-1:0] HSPLIT,
    input  logic                     HREADY,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic [1:0]               HRESP,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]            HMASTER,
    output logic                     HMASTLOCK
);

    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_SPLIT   = 2'b11;
    localparam logic [NO_OF_MASTERS-1:0] ONE = {{(NO_OF_MASTERS-1){1'b0}}, 1'b1};

    logic [MW-1:0]            grant_idx;
    logic [MW-1:0]            next_idx;
    logic [3:0]               rem;
    logic [3:0]               rem_next;
    logic [3:0]               burst_len_m1;
    logic [NO_OF_MASTERS-1:0] split_mask;
    logic [NO_OF_MASTERS-1:0] split_set;
    logic [NO_OF_MASTERS-1:0] eligible;
    logic                     completion;
    logic                     hold;
    logic                     arb_edge;
    logic                     found;

    always_comb begin
        case (HBURST)
            3'd2, 3'd3: burst_len_m1 = 4'd3;
            3'd4, 3'd5: burst_len_m1 = 4'd7;
            3'd6, 3'd7: burst_len_m1 = 4'd15;
            default:    burst_len_m1 = 4'd0;
        endcase
    end

    // SPLIT/RETRY completion abandons whatever remains of the burst
    assign completion = HREADY & HRESP[1];

    always_comb begin
        rem_next = rem;
        if (HREADY) begin
            if (HRESP[1])
                rem_next = 4'd0;
            else if (HTRANS == TRANS_NONSEQ)
                rem_next = burst_len_m1;
            else if (HTRANS == TRANS_SEQ && rem != 4'd0)
                rem_next = rem - 4'd1;
        end
    end

    assign hold     = HLOCK[grant_idx] | (rem_next != 4'd0);
    assign arb_edge = (HREADY & ~hold) | completion;
    assign eligible = HBUSREQ & ~split_mask;

    // Search starts just past the current owner so it only wins when alone
    always_comb begin
        next_idx = MW'(DEFAULT_MASTER);
        found    = 1'b0;
        for (int k = 1; k <= NO_OF_MASTERS; k++) begin
            if (!found && eligible[(int'(grant_idx) + k) % NO_OF_MASTERS]) begin
                next_idx = MW'((int'(grant_idx) + k) % NO_OF_MASTERS);
                found    = 1'b1;
            end
        end
    end

    assign split_set = (HRESP == RESP_SPLIT && !HREADY) ? (ONE << HMASTER) : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_idx  <= MW'(DEFAULT_MASTER);
            HGRANT     <= ONE << DEFAULT_MASTER;
            HMASTER    <= MW'(DEFAULT_MASTER);
            HMASTLOCK  <= 1'b0;
            rem        <= 4'd0;
            split_mask <= '0;
        end else begin
            split_mask <= (split_mask & ~HSPLIT) | split_set;
            if (HREADY) begin
                rem       <= rem_next;
                HMASTER   <= grant_idx;
                HMASTLOCK <= HLOCK[grant_idx];
                if (arb_edge) begin
                    grant_idx <= next_idx;
                    HGRANT    <= ONE << next_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, round robin, burst hold with wait states,
// locked sequence, split masking/release and idle fallback.
module tb_ahb_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] HBUSREQ, HLOCK, HSPLIT;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic [1:0] HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int n_cmp = 0;
    int n_err = 0;

    ahb_arbiter #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HSPLIT(HSPLIT), .HREADY(HREADY), .HTRANS(HTRANS), .HBURST(HBURST),
        .HRESP(HRESP), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] g, input int m);
        check({tag, ".grant"}, int'(HGRANT), int'(g));
        check({tag, ".master"}, int'(HMASTER), m);
    endtask

    initial begin
        HRESETn = 1'b0; HBUSREQ = 4'b0; HLOCK = 4'b0; HSPLIT = 4'b0;
        HREADY = 1'b1; HTRANS = 2'd0; HBURST = 3'd0; HRESP = 2'd0;

        // reset
        #12;
        chk("reset", 4'b0001, 0);
        check("reset.lock", int'(HMASTLOCK), 0);
        HRESETn = 1'b1;
        step(); step();
        chk("idle_after_reset", 4'b0001, 0);

        // round robin, SINGLE transfers
        HBUSREQ = 4'b1111; HTRANS = 2'd2; HBURST = 3'd0;
        step(); chk("rr1", 4'b0010, 0);
        step(); chk("rr2", 4'b0100, 1);
        step(); chk("rr3", 4'b1000, 2);
        step(); chk("rr4", 4'b0001, 3);
        step(); chk("rr5", 4'b0010, 0);

        // INCR8 from master 1 with master 2 waiting
        HBUSREQ = 4'b0010; HTRANS = 2'd0;
        step(); chk("b8_own", 4'b0010, 1);
        HTRANS = 2'd2; HBURST = 3'd5; HBUSREQ = 4'b0110;
        step(); chk("b8_nonseq", 4'b0010, 1);
        HTRANS = 2'd3;
        for (int k = 1; k <= 6; k++) begin
            step(); chk("b8_seq", 4'b0010, 1);
        end
        step(); chk("b8_last", 4'b0100, 1);
        HTRANS = 2'd0; HBUSREQ = 4'b0100;
        step(); chk("b8_handover", 4'b0100, 2);

        // INCR4 from master 2 with 3 wait states mid-burst
        HTRANS = 2'd2; HBURST = 3'd3; HBUSREQ = 4'b0101;
        step(); chk("b4_nonseq", 4'b0100, 2);
        HTRANS = 2'd3;
        step(); chk("b4_seq1", 4'b0100, 2);
        HREADY = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step(); chk("b4_wait", 4'b0100, 2);
        end
        HREADY = 1'b1;
        step(); chk("b4_seq2", 4'b0100, 2);
        step(); chk("b4_seq3", 4'b0001, 2);

        // locked sequence by master 3
        HTRANS = 2'd0; HBUSREQ = 4'b1000; HLOCK = 4'b1000;
        step(); chk("lk_grant", 4'b1000, 0);
        HBUSREQ = 4'b1111;
        step(); chk("lk_own", 4'b1000, 3);
        check("lk_own.lock", int'(HMASTLOCK), 1);
        HTRANS = 2'd2; HBURST = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            step(); chk("lk_xfer", 4'b1000, 3);
            check("lk_xfer.lock", int'(HMASTLOCK), 1);
        end
        HLOCK = 4'b0000;
        step(); chk("lk_release", 4'b0001, 3);
        check("lk_release.lock", int'(HMASTLOCK), 0);
        HTRANS = 2'd0;
        step(); chk("lk_handover", 4'b0010, 0);

        // asynchronous reset in the middle of a locked INCR16
        HBUSREQ = 4'b0010; HLOCK = 4'b0010;
        step(); chk("rst_own", 4'b0010, 1);
        HTRANS = 2'd2; HBURST = 3'd7;
        step();
        HTRANS = 2'd3;
        step(); chk("rst_mid", 4'b0010, 1);
        check("rst_mid.lock", int'(HMASTLOCK), 1);
        #2 HRESETn = 1'b0;
        #1 chk("rst_async", 4'b0001, 0);
        check("rst_async.lock", int'(HMASTLOCK), 0);
        HBUSREQ = 4'b0; HLOCK = 4'b0; HTRANS = 2'd0; HBURST = 3'd0;
        #3 HRESETn = 1'b1;

        // split of master 2, same-cycle set/clear, later release
        HBUSREQ = 4'b0100;
        step(); chk("sp_grant", 4'b0100, 0);
        step(); chk("sp_own", 4'b0100, 2);
        HTRANS = 2'd2; HBURST = 3'd3; HBUSREQ = 4'b1101;
        step(); chk("sp_nonseq", 4'b0100, 2);
        HTRANS = 2'd3; HRESP = 2'd3; HREADY = 1'b0; HSPLIT = 4'b0100;
        step(); chk("sp_resp1", 4'b0100, 2);
        HTRANS = 2'd0; HREADY = 1'b1; HSPLIT = 4'b0000;
        step(); chk("sp_resp2", 4'b1000, 2);
        HRESP = 2'd0;
        step(); chk("sp_next", 4'b0001, 3);
        step(); chk("sp_masked", 4'b1000, 0);
        HSPLIT = 4'b0100;
        step(); chk("sp_release", 4'b0001, 3);
        HSPLIT = 4'b0000;
        step(); chk("sp_regrant", 4'b0100, 0);

        // idle bus falls back to the default master
        HBUSREQ = 4'b0100;
        step(); chk("idle_own", 4'b0100, 2);
        HBUSREQ = 4'b0000;
        step(); chk("idle_default", 4'b0001, 2);
        step(); chk("idle_master", 4'b0001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter for `NO_OF_MASTERS` masters. It consumes master requests and locks, plus slave SPLIT signalling. It produces the bus grant, the current address-phase owner and the locked-sequence indication on the shared AHB interface. It sits upstream of the address/control mux and every slave: `HMASTER` steers the mux, and slaves use `HMASTER`/`HMASTLOCK`. It guarantees fixed-length bursts and locked sequences are never broken, and masks split masters until the slave releases them.

## Interface
- `NO_OF_MASTERS`, 4: number of masters, ≥2.
- `DEFAULT_MASTER`, 0: master granted when no eligible request exists; also the reset owner.
- `HCLK`  in  1  bus clock; all state updates on rising edge.
- `HRESETn`  in  1  reset; asynchronous assert, active-low.
- `HBUSREQ`  in  `NO_OF_MASTERS`  per-master bus request.
- `HLOCK`  in  `NO_OF_MASTERS`  per-master locked-access request.
- `HSPLIT`  in  `NO_OF_MASTERS`  OR of slave split-release vectors; bit i high for one cycle releases master i.
- `HREADY`  in  1  transfer-complete from the selected slave.
- `HTRANS`  in  2  muxed transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- `HBURST`  in  3  muxed burst type.
- `HRESP`  in  2  slave response (0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT).
- `HGRANT`  out  `NO_OF_MASTERS`  one-hot grant, registered.
- `HMASTER`  out  `$clog2(NO_OF_MASTERS)`  index of address-phase owner, registered.
- `HMASTLOCK`  out  1  current address phase is part of a locked sequence, registered.

## Operation
- **Accepted beat:** at a rising edge with `HREADY`=1 and `HTRANS` NONSEQ or SEQ.
- **Beat counter `rem`**
  - Loads on an accepted NONSEQ: length−1. Lengths: SINGLE/INCR=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16.
  - Decrements (saturating at 0) on an accepted SEQ.
  - Cleared by a SPLIT or RETRY completion.
  - `rem_next` is the value it takes at this edge.
- **Grant index:** `g` = index of the current `HGRANT` bit.
- **Hold:** `hold` = `HLOCK[g]` | (`rem_next` ≠ 0). INCR bursts are not held; the master re-issues NONSEQ after regaining the bus.
- **Arbitration edge:** rising edge with `HREADY`=1 and `hold`=0, or any SPLIT/RETRY completion edge (`HRESP`≥2 with `HREADY`=1). Completion edges override `hold`.
- **Selection**
  - Eligible set = `HBUSREQ` & ~`split_mask`.
  - Search round-robin starting at (g+1) mod N, wrapping, ending at g. The first eligible bit wins, so the current owner wins only if no other master is eligible.
  - Empty set → `DEFAULT_MASTER`. It is granted even if masked; it then drives IDLE.
- **`split_mask` (N bits)**
  - Bit `HMASTER` is set on the first response cycle (`HRESP`=3, `HREADY`=0).
  - Bit i is cleared when `HSPLIT[i]`=1.
  - Simultaneous set and clear of the same bit: set wins.
- **Ownership update:** at every edge with `HREADY`=1:
  - `HMASTER` ← g.
  - `HMASTLOCK` ← `HLOCK[g]`.

## Timing
- **Reset values**
  - `HGRANT` = one-hot `DEFAULT_MASTER`.
  - `HMASTER` = `DEFAULT_MASTER`.
  - `HMASTLOCK` = 0.
  - `split_mask` = 0; `rem` = 0.
- **Reset mid-burst or mid-split:** all state returns to reset values immediately (asynchronous).
- **Handover latency**
  - `HGRANT` changes at the arbitration edge E.
  - `HMASTER` changes at the first `HREADY`=1 edge after E.
  - The outgoing owner keeps the address bus for that one intervening address phase and drives IDLE.
  - Request-to-`HMASTER` is at least 2 cycles with zero wait states.
- **Wait states (`HREADY`=0):** `HGRANT`, `HMASTER`, `HMASTLOCK` and `rem` are frozen. `split_mask` set/clear still operate.
- **Fixed-length burst:** the grant cannot move before the edge accepting the last beat. Example: INCR4 NONSEQ at e1 gives `rem` 3,2,1,0 after e1..e4. The earliest `HGRANT` change is e4; `HMASTER` changes at e5.
- **Lock release:** when `HLOCK[g]` falls, arbitration is permitted at the next `HREADY` edge. `HMASTLOCK` drops at the same edge `HMASTER` updates.
- **SPLIT completion edge:** forces re-arbitration; the split master is excluded in the same evaluation.
- **Simultaneous NONSEQ acceptance and arbitration:** `hold` uses `rem_next`, so the burst-starting master keeps the grant.

## Test plan
- **Reset:** `DEFAULT_MASTER`=0, release reset with no requests → `HGRANT`=0001, `HMASTER`=0, `HMASTLOCK`=0; assert `HRESETn` low mid-burst → same values without a clock edge.
- **Round robin:** `HBUSREQ`=1111, SINGLE transfers, `HREADY`=1 → grant order 1,2,3,0,1. Each `HMASTER` change lags its `HGRANT` change by one cycle.
- **Burst hold:** master 1 issues INCR8 while master 2 requests → `HGRANT` stays 0010 through 7 SEQ beats, moves to 0100 at the last-beat edge. Insert 3 wait states mid-burst → handover delayed by exactly 3 cycles.
- **Lock:** master 3 holds `HLOCK` for 5 transfers with all others requesting → grant fixed on 3, `HMASTLOCK`=1 for those address phases. After `HLOCK` falls, grant moves to master 0.
- **Split:** slave answers master 2 with SPLIT (2 cycles) → `split_mask`=0100, grant moves to next requester, master 2 ignored while requesting. `HSPLIT`=0100 pulse → master 2 re-granted in round-robin turn. Same-cycle set/clear → stays masked.
- **Idle bus:** all requests drop with master 2 owning → `HGRANT`=0001 (`DEFAULT_MASTER`) at next `HREADY` edge.
